// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment codes are active-high and ordered {g, f, e, d, c, b, a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_scan_driver_bcd7seg.sv
// Combinational digit-to-segment decoder; any value above 9 shows a dash.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans two snapshotted BCD pairs (score, time) across a 4-digit 7-segment
// display with leading-zero blanking and per-pair blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 125,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bcd_a,
  input  logic [6:0] bcd_b,
  input  logic       lz_blank,
  input  logic [1:0] blink_en,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [3:0] AN_OFF  = {4{AN_ACT_LOW}};

  logic [PW-1:0] r_presc;
  digit_idx_t    r_idx;
  logic          r_first;
  logic          r_tick_d;
  logic [6:0]    r_snap_a;
  logic [6:0]    r_snap_b;
  logic [1:0]    r_blink_s;
  logic          r_lz_s;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame_tick;

  logic          w_scan_tick;
  logic          w_snap;
  logic [3:0]    w_digit;
  logic [2:0]    w_tens;
  logic          w_blank;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg7;

  assign w_scan_tick = (r_presc == PW'(DIV - 1));
  assign w_snap      = w_scan_tick && (r_first || (r_idx == 2'd3));

  // Prescaler, digit index and frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= 2'd0;
      r_first       <= 1'b1;
      r_tick_d      <= 1'b0;
      r_snap_a      <= 7'd0;
      r_snap_b      <= 7'd0;
      r_blink_s     <= 2'd0;
      r_lz_s        <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_presc      <= w_scan_tick ? '0 : r_presc + PW'(1);
      r_tick_d     <= w_scan_tick;
      r_frame_tick <= w_snap;
      if (w_scan_tick) begin
        // The first tick after reset starts a frame at digit 0 instead of advancing.
        r_idx   <= r_first ? 2'd0 : r_idx + 2'd1;
        r_first <= 1'b0;
      end
      if (w_snap) begin
        r_snap_a  <= bcd_a;
        r_snap_b  <= bcd_b;
        r_blink_s <= blink_en;
        r_lz_s    <= lz_blank;
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  // Digit select plus blanking decision for the current index
  always_comb begin
    w_tens  = 3'd0;
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_snap_b[3:0];
        w_blank = r_blink_phase && r_blink_s[0];
      end
      2'd1: begin
        w_tens  = r_snap_b[6:4];
        w_digit = (w_tens > 3'd6) ? 4'hF : {1'b0, w_tens};
        w_blank = (r_blink_phase && r_blink_s[0]) || (r_lz_s && (w_tens == 3'd0));
      end
      2'd2: begin
        w_digit = r_snap_a[3:0];
        w_blank = r_blink_phase && r_blink_s[1];
      end
      2'd3: begin
        w_tens  = r_snap_a[6:4];
        w_digit = (w_tens > 3'd6) ? 4'hF : {1'b0, w_tens};
        w_blank = (r_blink_phase && r_blink_s[1]) || (r_lz_s && (w_tens == 3'd0));
      end
      default: begin
        w_digit = 4'hF;
        w_blank = 1'b1;
      end
    endcase
  end

  bcd7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  assign w_seg7 = w_blank ? SEG_BLANK : w_dec;

  // Output register, polarity applied here so reset shows everything off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else if (r_tick_d) begin
      r_seg <= {1'b0, w_seg7} ^ SEG_OFF;
      r_an  <= (4'b0001 << r_idx) ^ AN_OFF;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver; expected display derived from the
// scan schedule (tick every DIV cycles, frame every 4 ticks) and the digit rules.
module tb_seg_scan_driver;

  localparam int DIV = 4;
  localparam int BF  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] bcd_a = 7'd0;
  logic [6:0] bcd_b = 7'd0;
  logic       lz_blank = 1'b0;
  logic [1:0] blink_en = 2'd0;
  logic [7:0] seg, seg_n;
  logic [3:0] an, an_n;
  logic       ft, ft_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m_frames = 0;
  logic [6:0] s_a, s_b;
  logic       s_lz;
  logic [1:0] s_bl;
  logic [7:0] m_seg;
  logic [3:0] m_an;
  logic       m_ft;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_FRAMES(BF),
                    .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bcd_a(bcd_a), .bcd_b(bcd_b), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg), .an(an), .frame_tick(ft)
  );

  seg_scan_driver #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_FRAMES(BF),
                    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .bcd_a(bcd_a), .bcd_b(bcd_b), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg_n), .an(an_n), .frame_tick(ft_n)
  );

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%02h exp=%02h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: glyph = 7'h3F;  1: glyph = 7'h06;  2: glyph = 7'h5B;  3: glyph = 7'h4F;
      4: glyph = 7'h66;  5: glyph = 7'h6D;  6: glyph = 7'h7D;  7: glyph = 7'h07;
      8: glyph = 7'h7F;  9: glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  // Slot 0..3 = B ones, B tens, A ones, A tens.
  function automatic logic [7:0] ref_seg(input int slot);
    int  v;
    int  pair_val;
    bit  is_a, is_tens;
    is_a     = (slot >= 2);
    is_tens  = (slot % 2 == 1);
    pair_val = is_a ? int'(s_a) : int'(s_b);
    v        = is_tens ? pair_val / 16 : pair_val % 16;
    if (s_bl[is_a ? 1 : 0] && ((m_frames / BF) % 2 == 1)) return 8'h00;
    if (is_tens && s_lz && v == 0) return 8'h00;
    if (v > (is_tens ? 6 : 9)) return 8'h40;
    return {1'b0, glyph(v)};
  endfunction

  task automatic check_outputs();
    logic [3:0] e_an_n;
    logic [7:0] e_seg_n;
    e_an_n  = ~m_an;
    e_seg_n = ~m_seg;
    chk_eq("an", {4'h0, an}, {4'h0, m_an});
    chk_eq("seg", seg, m_seg);
    chk_eq("frame_tick", {7'd0, ft}, {7'd0, m_ft});
    chk_eq("an_inv", {4'h0, an_n}, {4'h0, e_an_n});
    chk_eq("seg_inv", seg_n, e_seg_n);
    chk_eq("frame_tick_inv", {7'd0, ft_n}, {7'd0, m_ft});
  endtask

  task automatic step(input bit rnd);
    int slot;
    @(posedge clk);
    #1;
    cyc++;
    if ((cyc % DIV == 0) && (((cyc / DIV) - 1) % 4 == 0)) begin
      s_a  = bcd_a;
      s_b  = bcd_b;
      s_lz = lz_blank;
      s_bl = blink_en;
      m_frames++;
      m_ft = 1'b1;
    end else begin
      m_ft = 1'b0;
    end
    if ((cyc > DIV) && (cyc % DIV == 1)) begin
      slot  = (((cyc - 1) / DIV) - 1) % 4;
      m_an  = 4'b0001 << slot;
      m_seg = ref_seg(slot);
    end
    check_outputs();
    if (rnd && ($urandom_range(0, 5) == 0)) begin
      bcd_a    = 7'($urandom);
      bcd_b    = 7'($urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : $urandom);
      lz_blank = 1'($urandom);
      blink_en = 2'($urandom);
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) step(rnd);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cyc      = 0;
    m_frames = 0;
    m_an     = 4'h0;
    m_seg    = 8'h00;
    m_ft     = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    bcd_a = 7'h25; bcd_b = 7'h09; lz_blank = 1'b0; blink_en = 2'b00;
    do_reset();
    run(4, 1'b0);
    chk_eq("pre_tick_an", {4'h0, an}, 8'h00);
    step(1'b0);
    chk_eq("first_an", {4'h0, an}, 8'h01);
    chk_eq("first_seg", seg, 8'h6F);
    run(8, 1'b0);
    bcd_a = 7'h31;
    run(24, 1'b0);

    bcd_b = 7'h07; lz_blank = 1'b1;
    run(32, 1'b0);
    bcd_b = 7'h00;
    run(32, 1'b0);
    lz_blank = 1'b0; bcd_a = 7'h0C; bcd_b = 7'h72;
    run(32, 1'b0);
    bcd_a = 7'h48; bcd_b = 7'h16; blink_en = 2'b10;
    run(128, 1'b0);
    blink_en = 2'b00;
    run(32, 1'b0);

    run(800, 1'b1);

    bcd_a = 7'h25; bcd_b = 7'h09; lz_blank = 1'b0; blink_en = 2'b00;
    do_reset();
    run(14, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst_an", {4'h0, an}, 8'h00);
    chk_eq("async_rst_seg", seg, 8'h00);
    chk_eq("async_rst_an_inv", {4'h0, an_n}, 8'h0F);
    chk_eq("async_rst_seg_inv", seg_n, 8'hFF);
    do_reset();
    run(5, 1'b0);
    chk_eq("restart_an", {4'h0, an}, 8'h01);
    chk_eq("restart_seg", seg, 8'h6F);
    run(60, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
